// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one slave bus, grant held for the whole cyc tenure.
// A strobe watchdog turns a never-acknowledged access into an err termination.
module wb_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADR_WIDTH   = 64,
    parameter int DAT_WIDTH   = 64,
    parameter int SEL_WIDTH   = 8,
    parameter int TIMEOUT     = 255
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic [NUM_MASTERS-1:0]           m_cyc_i,
    input  logic [NUM_MASTERS-1:0]           m_stb_i,
    input  logic [NUM_MASTERS-1:0]           m_we_i,
    input  logic [NUM_MASTERS*ADR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DAT_WIDTH-1:0] m_dat_i,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0] m_sel_i,
    output logic [DAT_WIDTH-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]           m_ack_o,
    output logic [NUM_MASTERS-1:0]           m_err_o,
    output logic                             s_cyc_o,
    output logic                             s_stb_o,
    output logic                             s_we_o,
    output logic [ADR_WIDTH-1:0]             s_adr_o,
    output logic [DAT_WIDTH-1:0]             s_dat_o,
    output logic [SEL_WIDTH-1:0]             s_sel_o,
    input  logic [DAT_WIDTH-1:0]             s_dat_i,
    input  logic                             s_ack_i,
    input  logic                             s_err_i,
    output logic [NUM_MASTERS-1:0]           gnt_o,
    output logic                             busy_o
);
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int WDT_W = $clog2(TIMEOUT + 1);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_GRANTED = 1'b1;

    logic [0:0]             state_reg, state_next;
    logic [NUM_MASTERS-1:0] gnt_reg, gnt_next;
    logic [IDX_W-1:0]       gidx_reg, gidx_next;
    logic [IDX_W-1:0]       last_reg, last_next;
    logic [WDT_W-1:0]       wdt_reg, wdt_next;

    logic [ADR_WIDTH-1:0] adr_arr [NUM_MASTERS];
    logic [DAT_WIDTH-1:0] dat_arr [NUM_MASTERS];
    logic [SEL_WIDTH-1:0] sel_arr [NUM_MASTERS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
            assign adr_arr[gi] = m_adr_i[gi*ADR_WIDTH +: ADR_WIDTH];
            assign dat_arr[gi] = m_dat_i[gi*DAT_WIDTH +: DAT_WIDTH];
            assign sel_arr[gi] = m_sel_i[gi*SEL_WIDTH +: SEL_WIDTH];
        end
    endgenerate

    logic granted;
    logic g_cyc, g_stb, g_we;
    logic wdt_fire;

    assign granted = (state_reg == ST_GRANTED);
    assign g_cyc   = m_cyc_i[gidx_reg];
    assign g_stb   = m_stb_i[gidx_reg];
    assign g_we    = m_we_i[gidx_reg];

    // A same-cycle ack beats the watchdog so a late but valid response is never turned into an error.
    assign wdt_fire = granted & g_stb & (wdt_reg == WDT_W'(TIMEOUT)) & ~s_ack_i;

    assign s_cyc_o = granted & g_cyc;
    assign s_stb_o = granted & g_stb & ~wdt_fire;
    assign s_we_o  = granted & g_we;
    assign s_adr_o = granted ? adr_arr[gidx_reg] : '0;
    assign s_dat_o = granted ? dat_arr[gidx_reg] : '0;
    assign s_sel_o = granted ? sel_arr[gidx_reg] : '0;
    assign m_dat_o = s_dat_i;

    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_term
            assign m_ack_o[gi] = granted & (gidx_reg == IDX_W'(gi)) & s_ack_i;
            assign m_err_o[gi] = granted & (gidx_reg == IDX_W'(gi)) & (s_err_i | wdt_fire);
        end
    endgenerate

    assign gnt_o  = gnt_reg;
    assign busy_o = granted;

    // Round-robin pick: first cyc requester after the last released master.
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = int'(last_reg) + i;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            cand_idx = IDX_W'(cand);
            if (!pick_found && m_cyc_i[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        gidx_next  = gidx_reg;
        last_next  = last_reg;
        wdt_next   = '0;
        case (state_reg)
            ST_IDLE: begin
                if (pick_found) begin
                    state_next = ST_GRANTED;
                    gidx_next  = pick_idx;
                    gnt_next   = NUM_MASTERS'(1) << pick_idx;
                end
            end
            ST_GRANTED: begin
                if (!g_cyc) begin
                    state_next = ST_IDLE;
                    gnt_next   = '0;
                    last_next  = gidx_reg;
                end else if (g_stb && !s_ack_i && !s_err_i && !wdt_fire) begin
                    wdt_next = wdt_reg + WDT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_reg <= ST_IDLE;
            gnt_reg   <= '0;
            gidx_reg  <= '0;
            last_reg  <= IDX_W'(NUM_MASTERS - 1);
            wdt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            gidx_reg  <= gidx_next;
            last_reg  <= last_next;
            wdt_reg   <= wdt_next;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic, every cycle compared to a tenure-level model.
module tb_wb_arbiter;
    localparam int N  = 3;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = 8;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [N-1:0]    cyc, stb, we;
    logic [N*AW-1:0] adr;
    logic [N*DW-1:0] dat;
    logic [N*SW-1:0] sel;
    logic [DW-1:0]   m_dat_o;
    logic [N-1:0]    m_ack_o, m_err_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel_o;
    logic [DW-1:0]   s_dat;
    logic            s_ack, s_err;
    logic [N-1:0]    gnt_o;
    logic            busy_o;

    wb_arbiter #(
        .NUM_MASTERS(N), .ADR_WIDTH(AW), .DAT_WIDTH(DW), .SEL_WIDTH(SW), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we),
        .m_adr_i(adr), .m_dat_i(dat), .m_sel_i(sel),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
        .gnt_o(gnt_o), .busy_o(busy_o)
    );

    int checks   = 0;
    int errors   = 0;
    int cycle_no = 0;

    // Model: who owns the bus (-1 = nobody), who released last, how long the strobe has stalled.
    int owner = -1;
    int last  = N - 1;
    int stall = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle_no);
        end
    endtask

    task automatic idle_inputs();
        cyc = '0; stb = '0; we = '0; adr = '0; dat = '0; sel = '0;
        s_dat = '0; s_ack = 1'b0; s_err = 1'b0;
    endtask

    // Called at a negedge with inputs already set: compare, then advance model and DUT one clock.
    task automatic tick();
        logic          fire;
        logic [N-1:0]  e_gnt, e_ack, e_err;
        logic          e_cyc, e_stb, e_we;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic [SW-1:0] e_sel;
        int            n_owner, n_last, n_stall, c;
        #1;
        fire = 1'b0; e_gnt = '0; e_ack = '0; e_err = '0;
        e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_dat = '0; e_sel = '0;
        if (owner >= 0) begin
            fire         = stb[owner] && (stall == TO) && !s_ack;
            e_gnt[owner] = 1'b1;
            e_cyc        = cyc[owner];
            e_stb        = stb[owner] && !fire;
            e_we         = we[owner];
            e_adr        = adr[owner*AW +: AW];
            e_dat        = dat[owner*DW +: DW];
            e_sel        = sel[owner*SW +: SW];
            e_ack[owner] = s_ack;
            e_err[owner] = s_err || fire;
        end
        check("gnt",   64'(gnt_o),   64'(e_gnt));
        check("busy",  64'(busy_o),  64'(owner >= 0));
        check("s_cyc", 64'(s_cyc_o), 64'(e_cyc));
        check("s_stb", 64'(s_stb_o), 64'(e_stb));
        check("s_we",  64'(s_we_o),  64'(e_we));
        check("s_adr", 64'(s_adr_o), 64'(e_adr));
        check("s_dat", 64'(s_dat_o), 64'(e_dat));
        check("s_sel", 64'(s_sel_o), 64'(e_sel));
        check("m_ack", 64'(m_ack_o), 64'(e_ack));
        check("m_err", 64'(m_err_o), 64'(e_err));
        check("m_dat", 64'(m_dat_o), 64'(s_dat));
        if ((|m_ack_o) || (|m_err_o))
            $display("cycle %0d: gnt=%b ack=%b err=%b we=%b adr=%h", cycle_no, gnt_o, m_ack_o, m_err_o, s_we_o, s_adr_o);

        n_owner = owner; n_last = last; n_stall = 0;
        if (!rst_n) begin
            n_owner = -1;
            n_last  = N - 1;
        end else if (owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                c = (last + k) % N;
                if (n_owner < 0 && cyc[c]) n_owner = c;
            end
        end else if (!cyc[owner]) begin
            n_last  = owner;
            n_owner = -1;
        end else if (stb[owner] && !s_ack && !s_err && !fire) begin
            n_stall = stall + 1;
        end
        @(posedge clk);
        owner = n_owner; last = n_last; stall = n_stall;
        cycle_no++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    logic [DW-1:0] wval;
    logic [N-1:0]  ack_seen, ack_now;
    logic [N-1:0]  gq[$];
    int            tenures[$];
    int            gaps[$];
    int            zeros, err_at;
    logic          stb_at_err;

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tick();
        rst_n = 1'b1;

        // Read by master 0, slave acks one cycle after the grant.
        cyc[0] = 1'b1; stb[0] = 1'b1;
        adr[0*AW +: AW] = 64'h0000_8000_0000_0000;
        sel[0*SW +: SW] = 8'hff;
        tick();
        s_dat = {$urandom, $urandom};
        tick();
        s_ack = 1'b1;
        #1;
        check("rd_gnt", 64'(gnt_o), 64'd1);
        check("rd_adr", 64'(s_adr_o), 64'h0000_8000_0000_0000);
        check("rd_ack", 64'(m_ack_o), 64'd1);
        check("rd_dat", 64'(m_dat_o), 64'(s_dat));
        tick();
        idle_inputs();
        tick();
        tick();

        // Masters 0 and 1 request continuously, each dropping cyc after one ack.
        do_reset();
        s_ack = 1'b1;
        ack_seen = '0;
        for (int i = 0; i < 14; i++) begin
            for (int k = 0; k < 2; k++) begin
                cyc[k] = !ack_seen[k];
                stb[k] = cyc[k];
            end
            gq.push_back(gnt_o);
            #1;
            ack_now = m_ack_o;
            tick();
            ack_seen = ack_now;
        end
        zeros = 0;
        for (int i = 0; i < gq.size(); i++) begin
            if (gq[i] == '0) zeros++;
            else if (i == 0 || gq[i-1] == '0) begin
                tenures.push_back(int'(gq[i]));
                gaps.push_back(zeros);
                zeros = 0;
            end
        end
        check("alt_count", 64'(tenures.size() >= 4), 64'd1);
        for (int i = 0; i < 4 && i < tenures.size(); i++) begin
            check("alt_gnt", 64'(tenures[i]), 64'((i % 2 == 0) ? 1 : 2));
            if (i > 0) check("alt_gap", 64'(gaps[i]), 64'd1);
        end
        idle_inputs();
        tick();
        tick();

        // Master 1 owns the bus for 4 back-to-back writes while master 0 waits.
        do_reset();
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
        sel[1*SW +: SW] = 8'h0f;
        tick();
        cyc[0] = 1'b1; stb[0] = 1'b1;
        s_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wval = {$urandom, $urandom};
            dat[1*DW +: DW] = wval;
            adr[1*AW +: AW] = 64'h1000 + 64'(i * 8);
            #1;
            check("wr_gnt", 64'(gnt_o), 64'd2);
            check("wr_we",  64'(s_we_o), 64'd1);
            check("wr_dat", 64'(s_dat_o), 64'(wval));
            check("wr_ack", 64'(m_ack_o), 64'd2);
            tick();
        end
        cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0; s_ack = 1'b0;
        tick();
        tick();
        check("wr_next", 64'(gnt_o), 64'd1);
        idle_inputs();
        tick();
        tick();

        // Slave never responds: watchdog error 9 cycles after the master raises stb.
        do_reset();
        cyc[0] = 1'b1; stb[0] = 1'b1;
        err_at = -1; stb_at_err = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (m_err_o[0] && err_at < 0) begin
                err_at = i;
                stb_at_err = s_stb_o;
            end
            tick();
        end
        check("wdt_delay", 64'(err_at), 64'(TO + 1));
        check("wdt_stb", 64'(stb_at_err), 64'd0);
        check("wdt_hold", 64'(gnt_o), 64'd1);
        idle_inputs();
        tick();
        tick();

        // Reset in the middle of master 1's tenure; master 0 must win the next contention.
        do_reset();
        cyc[0] = 1'b1; stb[0] = 1'b1; s_ack = 1'b1;
        tick();
        tick();
        cyc[0] = 1'b0; stb[0] = 1'b0; s_ack = 1'b0;
        tick();
        cyc[1] = 1'b1; stb[1] = 1'b1;
        tick();
        tick();
        cyc[0] = 1'b1; stb[0] = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_gnt", 64'(gnt_o), 64'd0);
        check("rst_bus", 64'({s_cyc_o, s_stb_o, s_we_o}), 64'd0);
        check("rst_term", 64'(m_ack_o | m_err_o), 64'd0);
        tick();
        check("rst_win", 64'(gnt_o), 64'd1);
        idle_inputs();
        tick();
        tick();

        // Ack lands on the very cycle the watchdog would fire.
        do_reset();
        cyc[0] = 1'b1; stb[0] = 1'b1;
        tick();
        for (int i = 0; i < TO; i++) tick();
        s_ack = 1'b1;
        #1;
        check("ackto_ack", 64'(m_ack_o), 64'd1);
        check("ackto_err", 64'(m_err_o), 64'd0);
        check("ackto_stb", 64'(s_stb_o), 64'd1);
        tick();
        idle_inputs();
        tick();

        // Random traffic; every third 200-cycle block the slave hangs so the watchdog fires.
        for (int i = 0; i < 1500; i++) begin
            logic hang;
            hang  = ((i / 200) % 3) == 2;
            rst_n = ($urandom_range(0, 299) != 0);
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, hang ? 31 : 7) == 0) cyc[k] = ~cyc[k];
                stb[k] = cyc[k] & ($urandom_range(0, 3) != 0);
                we[k]  = 1'($urandom);
                adr[k*AW +: AW] = {$urandom, $urandom};
                dat[k*DW +: DW] = {$urandom, $urandom};
                sel[k*SW +: SW] = 8'($urandom);
            end
            s_dat = {$urandom, $urandom};
            s_ack = hang ? 1'b0 : ($urandom_range(0, 1) == 1);
            s_err = hang ? 1'b0 : ($urandom_range(0, 15) == 0);
            tick();
        end
        rst_n = 1'b1;
        idle_inputs();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
